// File: rtl/pipelined_decode_stage.sv
// ---------------------------------------------------------------------------
// pipelined_decode_stage
//
// Decode stage of the MIPS pipeline. It splits the fetched instruction into
// fields, reads both source registers from the integrated register file, and
// sign-extends the 16-bit immediate. All of this is registered into the ID/EX
// output register. A one-cycle stall is raised when the instruction being
// decoded uses the destination of a load that sits in the output register.
//
// Optional feature macro: WRITE_BYPASS_EN
//   defined   : a writeback to rs/rt in the same edge is forwarded into the
//               captured read data (write-through).
//   undefined : the captured read data is the pre-write register value.
//
// Parameters
//   DATA_WIDTH     : register / read data / immediate width (32 or 64)
//   REGISTER_COUNT : implemented registers (2..32). Reads of higher indices
//                    return 0 and writes to them are ignored.
//
// Ports
//   clock, reset_n            : rising-edge clock, synchronous active-low reset
//   fetched_instruction       : instruction word from fetch
//   fetch_valid               : fetched_instruction is valid
//   flush                     : load a bubble at the next edge
//   write_enable/_register/_data : writeback port into the register file
//   stall                     : combinational load-use stall to fetch
//   decode_valid              : output register holds a real instruction
//   opcode, rs, rt, rd, funct : registered instruction fields
//   read_data_1, read_data_2  : registered register[rs], register[rt]
//   sign_extended_immediate   : registered sign-extended instruction[15:0]
// ---------------------------------------------------------------------------
module pipelined_decode_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_COUNT = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           fetched_instruction,
    input  logic                  fetch_valid,
    input  logic                  flush,
    input  logic                  write_enable,
    input  logic [4:0]            write_register,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  stall,
    output logic                  decode_valid,
    output logic [5:0]            opcode,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [5:0]            funct,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic [DATA_WIDTH-1:0] sign_extended_immediate
);

    localparam int         IDX_W     = (REGISTER_COUNT > 2) ? $clog2(REGISTER_COUNT) : 1;
    localparam logic [5:0] OPCODE_LW = 6'h23;

    // Register 0 and indices beyond REGISTER_COUNT are never stored.
    function automatic logic is_implemented(input logic [4:0] idx);
        return (idx != 5'd0) && ({27'd0, idx} < 32'(REGISTER_COUNT));
    endfunction

    logic [DATA_WIDTH-1:0] regfile_q [REGISTER_COUNT];

    logic [5:0]            f_opcode_s;
    logic [4:0]            f_rs_s;
    logic [4:0]            f_rt_s;
    logic [4:0]            f_rd_s;
    logic [5:0]            f_funct_s;
    logic [DATA_WIDTH-1:0] f_imm_s;
    logic                  wr_ok_s;
    logic [DATA_WIDTH-1:0] rd1_raw_s;
    logic [DATA_WIDTH-1:0] rd2_raw_s;
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;

    logic                  valid_q,  valid_d;
    logic [5:0]            opcode_q, opcode_d;
    logic [4:0]            rs_q,     rs_d;
    logic [4:0]            rt_q,     rt_d;
    logic [4:0]            rd_q,     rd_d;
    logic [5:0]            funct_q,  funct_d;
    logic [DATA_WIDTH-1:0] rd1_q,    rd1_d;
    logic [DATA_WIDTH-1:0] rd2_q,    rd2_d;
    logic [DATA_WIDTH-1:0] imm_q,    imm_d;

    assign f_opcode_s = fetched_instruction[31:26];
    assign f_rs_s     = fetched_instruction[25:21];
    assign f_rt_s     = fetched_instruction[20:16];
    assign f_rd_s     = fetched_instruction[15:11];
    assign f_funct_s  = fetched_instruction[5:0];
    assign f_imm_s    = {{(DATA_WIDTH-16){fetched_instruction[15]}}, fetched_instruction[15:0]};
    assign wr_ok_s    = write_enable && is_implemented(write_register);

    // Load-use hazard: the load in ID/EX writes a register the fetched
    // instruction reads. A load into r0 produces nothing to wait for.
    assign stall = valid_q && (opcode_q == OPCODE_LW) && (rt_q != 5'd0) && fetch_valid
                   && ((f_rs_s == rt_q) || (f_rt_s == rt_q));

    // Register file: cleared by reset, written by writeback independent of stall/flush.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < REGISTER_COUNT; i++) begin
                regfile_q[i] <= '0;
            end
        end else if (wr_ok_s) begin
            regfile_q[write_register[IDX_W-1:0]] <= write_data;
        end
    end

    // Combinational register reads for both source fields, with optional write-through.
    always_comb begin
        rd1_raw_s = '0;
        rd2_raw_s = '0;
        if (is_implemented(f_rs_s)) begin
            rd1_raw_s = regfile_q[f_rs_s[IDX_W-1:0]];
        end else begin
            rd1_raw_s = '0;
        end
        if (is_implemented(f_rt_s)) begin
            rd2_raw_s = regfile_q[f_rt_s[IDX_W-1:0]];
        end else begin
            rd2_raw_s = '0;
        end
`ifdef WRITE_BYPASS_EN
        if (wr_ok_s && (write_register == f_rs_s)) begin
            rd1_s = write_data;
        end else begin
            rd1_s = rd1_raw_s;
        end
        if (wr_ok_s && (write_register == f_rt_s)) begin
            rd2_s = write_data;
        end else begin
            rd2_s = rd2_raw_s;
        end
`else
        rd1_s = rd1_raw_s;
        rd2_s = rd2_raw_s;
`endif
    end

    // ID/EX next state: flush and stall both insert a bubble; fields hold then.
    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        funct_d  = funct_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = 1'b0;
        end else begin
            valid_d  = fetch_valid;
            opcode_d = f_opcode_s;
            rs_d     = f_rs_s;
            rt_d     = f_rt_s;
            rd_d     = f_rd_s;
            funct_d  = f_funct_s;
            rd1_d    = rd1_s;
            rd2_d    = rd2_s;
            imm_d    = f_imm_s;
        end
    end

    // ID/EX output register with synchronous clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            opcode_q <= 6'd0;
            rs_q     <= 5'd0;
            rt_q     <= 5'd0;
            rd_q     <= 5'd0;
            funct_q  <= 6'd0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            funct_q  <= funct_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
        end
    end

    assign decode_valid            = valid_q;
    assign opcode                  = opcode_q;
    assign rs                      = rs_q;
    assign rt                      = rt_q;
    assign rd                      = rd_q;
    assign funct                   = funct_q;
    assign read_data_1             = rd1_q;
    assign read_data_2             = rd2_q;
    assign sign_extended_immediate = imm_q;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for pipelined_decode_stage. Two instances: the default
// 32-bit / 32-register build and a 64-bit / 16-register build. Stimulus
// pushes hand-computed expected ID/EX contents into a queue per instance;
// a negedge monitor pops and compares whenever decode_valid is high.
// ---------------------------------------------------------------------------
module tb_pipelined_decode_stage;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  fn;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] imm;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [31:0] fetched_instruction;
    logic        fetch_valid, flush, write_enable;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        stall, decode_valid;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] read_data_1, read_data_2, sign_extended_immediate;

    logic [31:0] b_fetched_instruction;
    logic        b_fetch_valid, b_flush, b_write_enable;
    logic [4:0]  b_write_register;
    logic [63:0] b_write_data;
    logic        b_stall, b_decode_valid;
    logic [5:0]  b_opcode, b_funct;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [63:0] b_read_data_1, b_read_data_2, b_sign_extended_immediate;

    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, a1, e2, a2;

    pipelined_decode_stage dut (
        .clock(clock), .reset_n(reset_n),
        .fetched_instruction(fetched_instruction), .fetch_valid(fetch_valid), .flush(flush),
        .write_enable(write_enable), .write_register(write_register), .write_data(write_data),
        .stall(stall), .decode_valid(decode_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .funct(funct), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .sign_extended_immediate(sign_extended_immediate)
    );

    pipelined_decode_stage #(.DATA_WIDTH(64), .REGISTER_COUNT(16)) dut64 (
        .clock(clock), .reset_n(reset_n),
        .fetched_instruction(b_fetched_instruction), .fetch_valid(b_fetch_valid), .flush(b_flush),
        .write_enable(b_write_enable), .write_register(b_write_register), .write_data(b_write_data),
        .stall(b_stall), .decode_valid(b_decode_valid), .opcode(b_opcode), .rs(b_rs), .rt(b_rt),
        .rd(b_rd), .funct(b_funct), .read_data_1(b_read_data_1), .read_data_2(b_read_data_2),
        .sign_extended_immediate(b_sign_extended_immediate)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ins, input logic [63:0] d1,
                                input logic [63:0] d2, input logic [63:0] imm);
        exp_t e;
        e.op  = ins[31:26];
        e.rs  = ins[25:21];
        e.rt  = ins[20:16];
        e.rd  = ins[15:11];
        e.fn  = ins[5:0];
        e.d1  = d1;
        e.d2  = d2;
        e.imm = imm;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fetch_valid  = 1'b0;
        flush        = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk(name, 256'({decode_valid, opcode, rs, rt, rd, funct, read_data_1, read_data_2,
                        sign_extended_immediate, stall}), 256'(1'b0));
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clock) begin
        if (decode_valid === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut32_unexpected_output: actual op=%0h rs=%0h rt=%0h required no output",
                         opcode, rs, rt);
            end else begin
                e1 = q1.pop_front();
                a1 = '{opcode, rs, rt, rd, funct, {32'd0, read_data_1}, {32'd0, read_data_2},
                       {32'd0, sign_extended_immediate}};
                chk("dut32_idex", 256'(a1), 256'(e1));
            end
        end
    end

    // Monitor for the 64-bit / 16-register instance.
    always @(negedge clock) begin
        if (b_decode_valid === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut64_unexpected_output: actual op=%0h rs=%0h required no output",
                         b_opcode, b_rs);
            end else begin
                e2 = q2.pop_front();
                a2 = '{b_opcode, b_rs, b_rt, b_rd, b_funct, b_read_data_1, b_read_data_2,
                       b_sign_extended_immediate};
                chk("dut64_idex", 256'(a2), 256'(e2));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        fetched_instruction = 32'd0;
        write_register = 5'd0;
        write_data = 32'd0;
        idle();
        b_fetched_instruction = 32'd0;
        b_fetch_valid = 1'b0;
        b_flush = 1'b0;
        b_write_enable = 1'b0;
        b_write_register = 5'd0;
        b_write_data = 64'd0;

        // Reset held for two edges under random inputs.
        for (int i = 0; i < 2; i++) begin
            fetched_instruction = $urandom;
            fetch_valid    = 1'($urandom);
            flush          = 1'($urandom);
            write_enable   = 1'($urandom);
            write_register = 5'($urandom);
            write_data     = $urandom;
            tick();
            #2;
            chk_zero("reset_outputs");
        end

        reset_n = 1'b1;
        idle();
        fetched_instruction = 32'h3B9AC9FF;
        fetch_valid = 1'b1;
        q1.push_back(mk(32'h3B9AC9FF, 64'd0, 64'd0, 64'h0000_0000_FFFF_C9FF));
        tick();

        idle();
        write_enable = 1'b1; write_register = 5'd8; write_data = 32'h0000_1234;
        tick();
        write_register = 5'd9; write_data = 32'h0000_0010;
        tick();

        idle();
        fetched_instruction = 32'h01095020; fetch_valid = 1'b1;
        q1.push_back(mk(32'h01095020, 64'h1234, 64'h10, 64'h5020));
        tick();

        // Same-edge write of r8 while reading it.
        write_enable = 1'b1; write_register = 5'd8; write_data = 32'h0000_CAFE;
`ifdef WRITE_BYPASS_EN
        q1.push_back(mk(32'h01095020, 64'hCAFE, 64'h10, 64'h5020));
`else
        q1.push_back(mk(32'h01095020, 64'h1234, 64'h10, 64'h5020));
`endif
        tick();

        // Same-edge write of r0 while reading it: always 0.
        fetched_instruction = 32'h00095020;
        write_register = 5'd0; write_data = 32'h0000_DEAD;
        q1.push_back(mk(32'h00095020, 64'd0, 64'h10, 64'h5020));
        tick();

        // lw r8,0(r9) followed by a dependent add.
        idle();
        fetched_instruction = 32'h8D280000; fetch_valid = 1'b1;
        q1.push_back(mk(32'h8D280000, 64'h10, 64'hCAFE, 64'd0));
        tick();
        fetched_instruction = 32'h01095020;
        q1.push_back(mk(32'h01095020, 64'hCAFE, 64'h10, 64'h5020));
        #2;
        chk("stall_load_use", 256'(stall), 256'(1'b1));
        tick();
        #2;
        chk("stall_after_bubble", 256'(stall), 256'(1'b0));
        chk("bubble_valid", 256'(decode_valid), 256'(1'b0));
        tick();

        // lw into r0 never stalls.
        fetched_instruction = 32'h8D200000;
        q1.push_back(mk(32'h8D200000, 64'h10, 64'd0, 64'd0));
        tick();
        fetched_instruction = 32'h00095020;
        q1.push_back(mk(32'h00095020, 64'd0, 64'h10, 64'h5020));
        #2;
        chk("stall_lw_r0", 256'(stall), 256'(1'b0));
        tick();

        // Flush with a valid instruction loads a bubble.
        fetched_instruction = 32'h01095020; flush = 1'b1;
        tick();
        #2;
        chk("flush_bubble", 256'(decode_valid), 256'(1'b0));
        idle();
        tick();

        // Mid-stream reset clears outputs and the register file.
        reset_n = 1'b0;
        fetched_instruction = 32'h01095020; fetch_valid = 1'b1;
        tick();
        #2;
        chk_zero("midstream_reset");
        reset_n = 1'b1;
        q1.push_back(mk(32'h01095020, 64'd0, 64'd0, 64'h5020));
        tick();
        idle();

        // 64-bit, 16-register instance.
        b_write_enable = 1'b1; b_write_register = 5'd4; b_write_data = 64'd7;
        tick();
        b_write_register = 5'd20; b_write_data = 64'd5;
        tick();
        b_write_enable = 1'b0;
        b_fetched_instruction = 32'h2008FFFC; b_fetch_valid = 1'b1;
        q2.push_back(mk(32'h2008FFFC, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC));
        tick();
        b_fetched_instruction = 32'h02840000;
        q2.push_back(mk(32'h02840000, 64'd0, 64'd7, 64'd0));
        tick();
        b_fetch_valid = 1'b0;
        repeat (3) tick();

        chk("dut32_queue_drained", 256'(q1.size()), 256'(0));
        chk("dut64_queue_drained", 256'(q2.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
